spi_master_ctrl: RTL

// - Command-level SPI initiator that drives our SPI slave + single-port RAM from the host side.
// - Takes one {op, byte} command, frames it on ss_n/mosi and, for read-data commands, captures
//   the 8-bit reply on miso and returns it to the host with a one-cycle rd_valid pulse.
// - Sits between the host/bench sequencer and spi_slave; SCK is clk, so there is no separate SCK port.

---
 rtl/spi_master_ctrl_if.sv | 43 ++++
 rtl/spi_master_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl_if.sv
// Host command port and SPI pins of the SPI initiator.
// The master modport is the controller side; slave is the host/bench side.
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       seq_err;

  modport master (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  miso,
    output cmd_ready,
    output ss_n,
    output mosi,
    output rd_data,
    output rd_valid,
    output busy,
    output seq_err
  );

  modport slave (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output miso,
    input  cmd_ready,
    input  ss_n,
    input  mosi,
    input  rd_data,
    input  rd_valid,
    input  busy,
    input  seq_err
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Command-level SPI initiator: frames {op, byte} on ss_n/mosi and
// captures an 8-bit reply on miso for read-data commands.
module spi_master_ctrl #(
  parameter int READ_WAIT = 2,
  parameter int GAP       = 1
) (
  input logic               clk,
  input logic               rst_n,
  spi_master_ctrl_if.master bus
);

  localparam int CW = (GAP > 16) ? $clog2(GAP) : 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    RECV,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    sh_q, sh_d;
  logic [7:0]    rx_q, rx_d;
  logic          rd_op_q, rd_op_d;
  logic          seen_q, seen_d;
  logic          ss_n_q, ss_n_d;
  logic          mosi_q, mosi_d;
  logic          ready_q, ready_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          seq_err_q, seq_err_d;

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = ~ready_q;
  assign bus.ss_n      = ss_n_q;
  assign bus.mosi      = mosi_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.seq_err   = seq_err_q;

  // Frame sequencing and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    rd_op_d    = rd_op_q;
    seen_d     = seen_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    ready_d    = ready_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    seq_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          state_d   = START;
          sh_d      = {bus.cmd_op, bus.cmd_data};
          rd_op_d   = (bus.cmd_op == 2'b11);
          ss_n_d    = 1'b0;
          mosi_d    = bus.cmd_op[1];
          ready_d   = 1'b0;
          seq_err_d = (bus.cmd_op == 2'b11) && !seen_q;
          if (bus.cmd_op == 2'b10) begin
            seen_d = 1'b1;
          end else if (bus.cmd_op == 2'b11) begin
            seen_d = 1'b0;
          end
        end
      end
      START: begin
        mosi_d  = sh_q[9];
        sh_d    = {sh_q[8:0], 1'b0};
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CW'(9)) begin
          mosi_d = 1'b0;
          cnt_d  = '0;
          if (!rd_op_q) begin
            state_d = STOP;
            ss_n_d  = 1'b1;
          end else if (READ_WAIT == 0) begin
            state_d = RECV;
          end else begin
            state_d = WAIT;
          end
        end else begin
          mosi_d = sh_q[9];
          sh_d   = {sh_q[8:0], 1'b0};
          cnt_d  = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == CW'(READ_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = RECV;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RECV: begin
        rx_d = {rx_q[6:0], bus.miso};
        if (cnt_q == CW'(7)) begin
          rd_data_d  = rx_d;
          rd_valid_d = 1'b1;
          ss_n_d     = 1'b1;
          cnt_d      = '0;
          state_d    = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CW'(GAP - 1)) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      rd_op_q    <= 1'b0;
      seen_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      rd_op_q    <= rd_op_d;
      seen_q     <= seen_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      seq_err_q  <= seq_err_d;
    end
  end

endmodule
